// File: rtl/pipe_adder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pipe_adder
// Brief    : Pipelined CHUNK-bit-per-stage adder/subtractor, whole-pipe stall.
// Revision : 1.0
// ============================================================================
module pipe_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;

  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  be_q  [STAGES];
  logic [WIDTH-1:0]  be_d  [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic [STAGES-1:0] carry_q, carry_d;
  logic [STAGES-1:0] valid_q, valid_d;
  logic              ovf_q, ovf_d;
  logic [CHUNK:0]    w_slice [STAGES];
  logic [WIDTH-1:0]  w_b_eff;
  logic              w_en;

  assign w_en      = !valid_q[LAST] || out_ready;
  assign in_ready  = w_en;
  assign out_valid = valid_q[LAST];
  assign s         = sum_q[LAST];
  assign cout      = carry_q[LAST];
  assign ovf       = ovf_q;

  always_comb begin
    a_d     = '{default: '0};
    be_d    = '{default: '0};
    sum_d   = '{default: '0};
    w_slice = '{default: '0};
    carry_d = '0;
    valid_d = '0;

    // Subtraction is a + ~b + 1; borrow-in folds into the same carry-in.
    w_b_eff    = b ^ {WIDTH{sub}};
    a_d[0]     = a;
    be_d[0]    = w_b_eff;
    valid_d[0] = in_valid;
    w_slice[0] = {1'b0, a[CHUNK-1:0]} + {1'b0, w_b_eff[CHUNK-1:0]}
               + {{CHUNK{1'b0}}, cin ^ sub};
    sum_d[0][CHUNK-1:0] = w_slice[0][CHUNK-1:0];
    carry_d[0]          = w_slice[0][CHUNK];

    for (int k = 1; k < STAGES; k++) begin
      a_d[k]     = a_q[k-1];
      be_d[k]    = be_q[k-1];
      sum_d[k]   = sum_q[k-1];
      valid_d[k] = valid_q[k-1];
      w_slice[k] = {1'b0, a_q[k-1][k*CHUNK +: CHUNK]}
                 + {1'b0, be_q[k-1][k*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, carry_q[k-1]};
      sum_d[k][k*CHUNK +: CHUNK] = w_slice[k][CHUNK-1:0];
      carry_d[k]                 = w_slice[k][CHUNK];
    end

    ovf_d = (a_d[LAST][WIDTH-1] == be_d[LAST][WIDTH-1]) &&
            (sum_d[LAST][WIDTH-1] != a_d[LAST][WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '{default: '0};
      be_q    <= '{default: '0};
      sum_q   <= '{default: '0};
      carry_q <= '0;
      valid_q <= '0;
      ovf_q   <= 1'b0;
    end else if (w_en) begin
      a_q     <= a_d;
      be_q    <= be_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_adder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pipe_adder
// Brief    : Bench for pipe_adder at 32/4, 8/8, 16/4 and 64/16 configurations.
// Revision : 1.0
// ============================================================================
module tb_pipe_adder;

  localparam int NDUT = 4;
  localparam int WD [NDUT] = '{32, 8, 16, 64};
  localparam int ST [NDUT] = '{8, 1, 4, 4};

  typedef struct packed {
    logic [63:0] s;
    logic        cout;
    logic        ovf;
    int          due;
  } ent_t;

  logic        clk, rst, in_valid, out_ready, cin, sub;
  logic [63:0] a64, b64;

  logic        ir0, ir1, ir2, ir3, ov0, ov1, ov2, ov3;
  logic        co0, co1, co2, co3, of0, of1, of2, of3;
  logic [31:0] s0;
  logic [7:0]  s1;
  logic [15:0] s2;
  logic [63:0] s3;

  logic        ir_v [NDUT];
  logic        ov_v [NDUT];
  logic        co_v [NDUT];
  logic        of_v [NDUT];
  logic [63:0] s_v  [NDUT];

  int   nchk = 0;
  int   nerr = 0;
  int   hs0  = 0;
  int   encnt [NDUT];
  ent_t mq [NDUT][$];

  pipe_adder #(.WIDTH(32), .CHUNK(4)) u_d0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0),
    .a(a64[31:0]), .b(b64[31:0]), .cin(cin), .sub(sub),
    .out_valid(ov0), .out_ready(out_ready), .s(s0), .cout(co0), .ovf(of0));
  pipe_adder #(.WIDTH(8), .CHUNK(8)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1),
    .a(a64[7:0]), .b(b64[7:0]), .cin(cin), .sub(sub),
    .out_valid(ov1), .out_ready(out_ready), .s(s1), .cout(co1), .ovf(of1));
  pipe_adder #(.WIDTH(16), .CHUNK(4)) u_d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2),
    .a(a64[15:0]), .b(b64[15:0]), .cin(cin), .sub(sub),
    .out_valid(ov2), .out_ready(out_ready), .s(s2), .cout(co2), .ovf(of2));
  pipe_adder #(.WIDTH(64), .CHUNK(16)) u_d3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir3),
    .a(a64), .b(b64), .cin(cin), .sub(sub),
    .out_valid(ov3), .out_ready(out_ready), .s(s3), .cout(co3), .ovf(of3));

  always_comb begin
    ir_v[0] = ir0; ir_v[1] = ir1; ir_v[2] = ir2; ir_v[3] = ir3;
    ov_v[0] = ov0; ov_v[1] = ov1; ov_v[2] = ov2; ov_v[3] = ov3;
    co_v[0] = co0; co_v[1] = co1; co_v[2] = co2; co_v[3] = co3;
    of_v[0] = of0; of_v[1] = of1; of_v[2] = of2; of_v[3] = of3;
    s_v[0]  = {32'd0, s0};
    s_v[1]  = {56'd0, s1};
    s_v[2]  = {48'd0, s2};
    s_v[3]  = s3;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Golden result from plain unsigned / signed arithmetic on W-bit operands.
  function automatic ent_t gold(input int w, input logic [63:0] ta, input logic [63:0] tb_,
                                input logic tc, input logic ts);
    ent_t e;
    logic [79:0]        mask, ua, ub, uc, full;
    logic signed [79:0] sa, sb, sc, sr, half;
    mask = (80'd1 << w) - 80'd1;
    ua   = {16'd0, ta} & mask;
    ub   = {16'd0, tb_} & mask;
    uc   = {79'd0, tc};
    half = $signed(80'd1 << (w - 1));
    sa   = $signed(ua);
    if (ua[w-1]) sa = sa - (half <<< 1);
    sb   = $signed(ub);
    if (ub[w-1]) sb = sb - (half <<< 1);
    sc   = $signed(uc);
    if (ts) begin
      full   = ua - ub - uc;
      e.cout = (ua >= ub + uc);
      sr     = sa - sb - sc;
    end else begin
      full   = ua + ub + uc;
      e.cout = full[w];
      sr     = sa + sb + sc;
    end
    e.s   = full[63:0] & mask[63:0];
    e.ovf = (sr >= half) || (sr < -half);
    e.due = 0;
    return e;
  endfunction

  // Model: each accepted set becomes visible after STAGES-1 further enabled edges.
  initial begin
    logic mv;
    ent_t e;
    for (int d = 0; d < NDUT; d++) encnt[d] = 0;
    forever begin
      @(posedge clk);
      for (int d = 0; d < NDUT; d++) begin
        if (rst) begin
          mq[d].delete();
        end else begin
          mv = (mq[d].size() > 0) && (mq[d][0].due <= encnt[d]);
          if (!mv || out_ready) begin
            if (mv) void'(mq[d].pop_front());
            encnt[d]++;
            if (in_valid) begin
              e     = gold(WD[d], a64, b64, cin, sub);
              e.due = encnt[d] + ST[d] - 1;
              mq[d].push_back(e);
            end
          end
        end
      end
    end
  end

  initial begin
    logic mv;
    @(posedge clk);
    forever begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
        mv = (mq[d].size() > 0) && (mq[d][0].due <= encnt[d]);
        chk($sformatf("out_valid[%0d]", d), ov_v[d], mv);
        chk($sformatf("in_ready[%0d]", d), ir_v[d], !mv || out_ready);
        if (mv) begin
          chk($sformatf("s[%0d]", d), s_v[d], mq[d][0].s);
          chk($sformatf("cout[%0d]", d), co_v[d], mq[d][0].cout);
          chk($sformatf("ovf[%0d]", d), of_v[d], mq[d][0].ovf);
        end
      end
      if (ov_v[0] && out_ready) hs0++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    a64 = {$urandom, $urandom};
    b64 = {$urandom, $urandom};
    cin = 1'($urandom_range(1));
    sub = 1'($urandom_range(1));
  endtask

  // One isolated operation with exact-cycle latency and literal result checks.
  task automatic directed(input string nm, input int d, input logic [63:0] ta,
                          input logic [63:0] tb_, input logic tc, input logic ts,
                          input logic [63:0] es, input logic ec, input logic eo);
    step();
    a64 = ta; b64 = tb_; cin = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < ST[d]; i++) begin
      @(negedge clk);
      chk({nm, ".valid"}, ov_v[d], (i == ST[d] - 1));
      if (i == ST[d] - 1) begin
        chk({nm, ".s"}, s_v[d], es);
        chk({nm, ".cout"}, co_v[d], ec);
        chk({nm, ".ovf"}, of_v[d], eo);
      end else begin
        step();
      end
    end
    step();
    @(negedge clk);
    chk({nm, ".once"}, ov_v[d], 1'b0);
    repeat (10) step();
  endtask

  initial begin
    int hs_start;
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    cin = 1'b0; sub = 1'b0; a64 = 64'h1234_5678_9ABC_DEF0; b64 = 64'h0FED_CBA9_8765_4321;

    repeat (2) begin
      step();
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
        chk($sformatf("reset.valid[%0d]", d), ov_v[d], 1'b0);
        chk($sformatf("reset.s[%0d]", d), s_v[d], 64'd0);
        chk($sformatf("reset.cout[%0d]", d), co_v[d], 1'b0);
        chk($sformatf("reset.ovf[%0d]", d), of_v[d], 1'b0);
      end
    end
    step();
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) chk($sformatf("idle.in_ready[%0d]", d), ir_v[d], 1'b1);
    repeat (3) step();

    directed("ripple",  0, 64'hFFFF_FFFF, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0);
    directed("borrow",  0, 64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFE, 1'b0, 1'b0);
    directed("sub_ovf", 0, 64'h8000_0000, 64'd1, 1'b0, 1'b1, 64'h7FFF_FFFF, 1'b1, 1'b1);
    directed("w8_ovf",  1, 64'h7F, 64'd1, 1'b0, 1'b0, 64'h80, 1'b0, 1'b1);
    directed("w16_ovf", 2, 64'h7FFF, 64'd1, 1'b0, 1'b0, 64'h8000, 1'b0, 1'b1);
    directed("w16_sbc", 2, 64'h8000, 64'd0, 1'b1, 1'b1, 64'h7FFF, 1'b1, 1'b1);
    directed("w64_ovf", 3, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
             64'h8000_0000_0000_0000, 1'b0, 1'b1);
    directed("w64_wrap", 3, 64'd0, 64'd1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);

    hs_start = hs0;
    for (int i = 0; i < 20; i++) begin
      step();
      rand_ops();
      in_valid = 1'b1;
    end
    step();
    in_valid = 1'b0;
    repeat (12) step();
    chk("stream.count", 64'(hs0 - hs_start), 64'd20);

    hs_start = hs0;
    for (int i = 0; i < 15; i++) begin
      step();
      rand_ops();
      in_valid  = 1'b1;
      out_ready = !(i >= 9 && i <= 13);
    end
    step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (14) step();
    chk("stall.count", 64'(hs0 - hs_start), 64'd10);

    hs_start = hs0;
    for (int i = 0; i < 5; i++) begin
      step();
      rand_ops();
      in_valid = 1'b1;
    end
    step();
    rst = 1'b1;
    rand_ops();
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rstmid.valid", ov0, 1'b0);
    repeat (12) step();
    chk("rstmid.count", 64'(hs0 - hs_start), 64'd0);
    directed("post_rst", 0, 64'h1234_5678, 64'h1111_1111, 1'b0, 1'b0,
             64'h2345_6789, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
`default_nettype wire
